solve_sequencer: RTL and testbench

Controller that sequences one machine at a time through the GF(2) solve path: the RREF engine followed by the solution enumerator. It consumes the enumerator's 8-bit solution stream, tracks the minimum Hamming weight per machine, and reports that minimum (the fewest button presses) per machine. It also keeps a running total across a batch of machines. The block sits between the job front-end (matrix loader) and the result sink.

---
 rtl/solve_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_solve_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/solve_sequencer.sv
// solve_sequencer
//
// Runs one machine at a time through the GF(2) solve path: it kicks the RREF
// engine, waits for it (guarded by a watchdog), kicks the solution
// enumerator, takes the enumerator's solution stream and keeps the smallest
// popcount seen. It then reports that minimum with a running batch total.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   job_valid/job_ready      job hand-off from the matrix loader; job_last
//                            marks the final machine of a batch
//   rref_start, rref_done    start pulse to / completion (level or pulse)
//                            from the RREF engine
//   enum_start               start pulse to the enumerator
//   sol_t*                   8-bit solution stream from the enumerator
//   res_*                    per-machine result to the sink
//   busy                     high whenever the sequencer is not idle
//   error                    sticky RREF watchdog flag
//   state_dbg                current FSM state encoding (observation only)
//
// Handshake semantics (all valid/ready pairs): a transfer happens on a rising
// clk edge where valid and ready are both high. A source that raises valid
// holds valid and its payload steady until that transfer. Every ready and
// valid driven by this block is a function of the registered state only, so
// it never depends combinationally on the partner's valid or ready.

module solve_sequencer #(
    parameter int                   TOTAL_W   = 32,
    parameter int                   TIMEOUT_W = 16,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT   = 16'hFFFF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               job_valid,
    input  logic               job_last,
    output logic               job_ready,
    output logic               rref_start,
    input  logic               rref_done,
    output logic               enum_start,
    input  logic               sol_tvalid,
    input  logic [7:0]         sol_tdata,
    input  logic               sol_tlast,
    output logic               sol_tready,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [3:0]         res_min,
    output logic [TOTAL_W-1:0] res_total,
    output logic               res_last,
    output logic               busy,
    output logic               error,
    output logic [2:0]         state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RREF_START = 3'd1,
        S_RREF_WAIT  = 3'd2,
        S_ENUM_START = 3'd3,
        S_COLLECT    = 3'd4,
        S_REPORT     = 3'd5
    } state_t;

    // 4'hF doubles as "no solution yet" and "timed out"; a real popcount of
    // an 8-bit vector never exceeds 8.
    localparam logic [3:0] MIN_NONE = 4'hF;

    state_t               state_q, state_d;
    logic                 last_q;
    logic [TIMEOUT_W-1:0] wd_cnt_q;
    logic [3:0]           min_q;
    logic [TOTAL_W-1:0]   total_q;
    logic                 error_q;

    logic                 wd_hit;
    logic                 sol_beat;
    logic [3:0]           beat_w;
    logic [3:0]           add_val;
    logic [TOTAL_W:0]     sum_ext;
    logic [TOTAL_W-1:0]   sat_total;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    // The counter holds the number of RREF_WAIT cycles already spent, so the
    // last allowed cycle is the one where it equals TIMEOUT-1.
    assign wd_hit   = (state_q == S_RREF_WAIT) && (wd_cnt_q == TIMEOUT - TIMEOUT_W'(1));
    assign sol_beat = sol_tvalid && sol_tready;
    assign beat_w   = popcount8(sol_tdata);

    // A timed-out machine carries the sentinel but adds nothing to the total.
    assign add_val   = (min_q == MIN_NONE) ? 4'd0 : min_q;
    assign sum_ext   = {1'b0, total_q} + (TOTAL_W + 1)'(add_val);
    assign sat_total = sum_ext[TOTAL_W] ? {TOTAL_W{1'b1}} : sum_ext[TOTAL_W-1:0];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore outputs
    always_comb begin
        state_d    = state_q;
        job_ready  = 1'b0;
        rref_start = 1'b0;
        enum_start = 1'b0;
        sol_tready = 1'b0;
        res_valid  = 1'b0;
        res_min    = MIN_NONE;
        res_total  = '0;
        res_last   = 1'b0;
        busy       = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                job_ready = 1'b1;
                busy      = 1'b0;
                if (job_valid) state_d = S_RREF_START;
            end
            S_RREF_START: begin
                // Suppressed while rst is high so no pulse escapes on the
                // reset cycle.
                rref_start = !rst;
                state_d    = S_RREF_WAIT;
            end
            S_RREF_WAIT: begin
                // Completion takes priority over a watchdog expiry in the
                // same cycle.
                if (rref_done)   state_d = S_ENUM_START;
                else if (wd_hit) state_d = S_REPORT;
            end
            S_ENUM_START: begin
                enum_start = !rst;
                state_d    = S_COLLECT;
            end
            S_COLLECT: begin
                sol_tready = 1'b1;
                if (sol_tvalid && sol_tlast) state_d = S_REPORT;
            end
            S_REPORT: begin
                res_valid = 1'b1;
                res_min   = min_q;
                res_total = sat_total;
                res_last  = last_q;
                if (res_ready) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q   <= 1'b0;
            wd_cnt_q <= '0;
            min_q    <= MIN_NONE;
            total_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (job_valid) begin
                        last_q   <= job_last;
                        wd_cnt_q <= '0;
                    end
                end
                S_RREF_WAIT: begin
                    wd_cnt_q <= wd_cnt_q + TIMEOUT_W'(1);
                    if (!rref_done && wd_hit) begin
                        error_q <= 1'b1;
                        min_q   <= MIN_NONE;
                    end
                end
                S_ENUM_START: begin
                    min_q <= MIN_NONE;
                end
                S_COLLECT: begin
                    if (sol_beat && (beat_w < min_q)) min_q <= beat_w;
                end
                S_REPORT: begin
                    // The last machine of a batch closes the batch total.
                    if (res_ready) total_q <= last_q ? '0 : sat_total;
                end
                default: begin
                end
            endcase
        end
    end

    assign error     = error_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_solve_sequencer.sv
// Bench for solve_sequencer: directed jobs with hand-computed minima/totals.
// Inputs change 1 ns after a rising edge; outputs are sampled on falling edges.
module tb_solve_sequencer;

    localparam int TOTAL_W = 32;
    localparam int TO      = 20;
    localparam int RW      = TOTAL_W + 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic               job_valid = 1'b0;
    logic               job_last  = 1'b0;
    logic               job_ready;
    logic               rref_start;
    logic               rref_done = 1'b0;
    logic               enum_start;
    logic               sol_tvalid = 1'b0;
    logic [7:0]         sol_tdata  = 8'h00;
    logic               sol_tlast  = 1'b0;
    logic               sol_tready;
    logic               res_valid;
    logic               res_ready = 1'b0;
    logic [3:0]         res_min;
    logic [TOTAL_W-1:0] res_total;
    logic               res_last;
    logic               busy;
    logic               error;
    logic [2:0]         state_dbg;

    solve_sequencer #(
        .TOTAL_W  (TOTAL_W),
        .TIMEOUT_W(16),
        .TIMEOUT  (16'd20)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .job_valid (job_valid),
        .job_last  (job_last),
        .job_ready (job_ready),
        .rref_start(rref_start),
        .rref_done (rref_done),
        .enum_start(enum_start),
        .sol_tvalid(sol_tvalid),
        .sol_tdata (sol_tdata),
        .sol_tlast (sol_tlast),
        .sol_tready(sol_tready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_min   (res_min),
        .res_total (res_total),
        .res_last  (res_last),
        .busy      (busy),
        .error     (error),
        .state_dbg (state_dbg)
    );

    int tests    = 0;
    int failed   = 0;
    int enum_cnt = 0;

    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] mon_exp;
    logic [7:0]    stim[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (enum_start) enum_cnt++;
        if (!rst && res_valid && res_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                failed++;
                $display("FAIL result_unexpected: got min=%0d total=%0d last=%0b, required no result",
                         res_min, res_total, res_last);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({res_min, res_total, res_last} !== mon_exp) begin
                    failed++;
                    $display("FAIL result: got min=%0d total=%0d last=%0b, required min=%0d total=%0d last=%0b",
                             res_min, res_total, res_last,
                             mon_exp[RW-1 -: 4], mon_exp[TOTAL_W:1], mon_exp[0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hands over one job; returns at the falling edge of the RREF_START cycle.
    task automatic issue_job(input logic last);
        int w;
        w = 0;
        @(negedge clk);
        while (!job_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("job_ready_wait", job_ready, 1);
        tick();
        job_valid = 1'b1;
        job_last  = last;
        tick();
        job_valid = 1'b0;
        job_last  = 1'b0;
        @(negedge clk);
        check("rref_start_rise", rref_start, 1);
        check("busy_after_accept", busy, 1);
        check("job_ready_busy", job_ready, 0);
    endtask

    // lat < 0: never answer, expect the watchdog REPORT TO+1 cycles after
    // rref_start. Otherwise pulse rref_done lat cycles after rref_start (lat>=2)
    // and present the first beat early while the sequencer is not yet ready.
    task automatic rref_phase(input int lat);
        tick();
        @(negedge clk);
        check("rref_start_pulse", rref_start, 0);
        if (lat < 0) begin
            for (int i = 2; i <= TO; i++) tick();
            @(negedge clk);
            check("wd_not_early", res_valid, 0);
            tick();
            @(negedge clk);
            check("wd_report", res_valid, 1);
            check("wd_error", error, 1);
        end else begin
            for (int i = 2; i <= lat; i++) tick();
            rref_done = 1'b1;
            tick();
            rref_done  = 1'b0;
            sol_tvalid = 1'b1;
            sol_tdata  = stim[0];
            sol_tlast  = (stim.size() == 1);
        end
    endtask

    // Starts at the ENUM_START cycle; returns at the falling edge of the
    // first REPORT cycle.
    task automatic stream_phase(input bit rnd);
        int  idx;
        int  cyc;
        bit  acc;
        idx = 0;
        cyc = 0;
        while (idx < stim.size() && cyc < 200) begin
            @(negedge clk);
            if (cyc == 0) begin
                check("enum_start_rise", enum_start, 1);
                check("tready_low_in_enum", sol_tready, 0);
            end
            if (cyc == 1) begin
                check("enum_start_pulse", enum_start, 0);
                check("tready_in_collect", sol_tready, 1);
            end
            acc = sol_tvalid && sol_tready;
            if (acc) idx++;
            tick();
            cyc++;
            if (idx < stim.size()) begin
                sol_tvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                sol_tdata  = stim[idx];
                sol_tlast  = (idx == stim.size() - 1);
            end else begin
                sol_tvalid = 1'b0;
                sol_tdata  = 8'h00;
                sol_tlast  = 1'b0;
            end
        end
        check("stream_drained", idx, stim.size());
        @(negedge clk);
        check("report_after_tlast", res_valid, 1);
    endtask

    // Starts at the falling edge of the first REPORT cycle.
    task automatic result_phase(input int hold, input logic eerr);
        logic [RW-1:0] snap;
        bit            stable;
        snap   = {res_min, res_total, res_last};
        stable = 1'b1;
        check("error_flag", error, eerr);
        for (int i = 0; i < hold; i++) begin
            tick();
            @(negedge clk);
            if (!res_valid || ({res_min, res_total, res_last} !== snap)) stable = 1'b0;
        end
        check("res_stable", stable, 1);
        tick();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        @(negedge clk);
        check("job_ready_after_result", job_ready, 1);
        check("res_valid_drop", res_valid, 0);
    endtask

    task automatic run_job(input logic last, input int lat, input bit rnd, input int hold,
                           input logic [3:0] emin, input logic [31:0] etotal, input logic eerr);
        int e0;
        exp_q.push_back({emin, etotal, last});
        e0 = enum_cnt;
        issue_job(last);
        rref_phase(lat);
        if (lat >= 0) stream_phase(rnd);
        result_phase(hold, eerr);
        check("enum_pulse_count", enum_cnt - e0, (lat >= 0) ? 1 : 0);
    endtask

    task automatic check_idle_after_reset(input string tag);
        check({tag, "_job_ready"}, job_ready, 1);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_res_min"}, res_min, 4'hF);
        check({tag, "_res_total"}, res_total, 0);
        check({tag, "_tready"}, sol_tready, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_after_reset("reset");
        check("reset_rref_start", rref_start, 0);
        check("reset_enum_start", enum_start, 0);
        check("reset_res_last", res_last, 0);
        tick();
        rst = 1'b0;

        // Single machine: weights 3,1,3 -> min 1, closes its batch
        stim = '{8'hB0, 8'h40, 8'hE0};
        run_job(1'b1, 3, 1'b0, 0, 4'd1, 32'd1, 1'b0);

        // Batch of three: minima 2,3,1 -> totals 2,5,6, then the batch resets
        stim = '{8'h03, 8'h07};
        run_job(1'b0, 3, 1'b0, 0, 4'd2, 32'd2, 1'b0);
        stim = '{8'hFF, 8'h0E, 8'h1F};
        run_job(1'b0, 4, 1'b0, 0, 4'd3, 32'd5, 1'b0);
        stim = '{8'h81, 8'hC3, 8'h40};
        run_job(1'b1, 2, 1'b0, 0, 4'd1, 32'd6, 1'b0);
        stim = '{8'hF0, 8'h3C, 8'h18};
        run_job(1'b0, 3, 1'b0, 0, 4'd2, 32'd2, 1'b0);

        // Back-pressure on both sides, then a single zero beat
        stim = '{8'hFE, 8'h11, 8'hC0, 8'h80, 8'hF7};
        run_job(1'b0, 3, 1'b1, 10, 4'd1, 32'd3, 1'b0);
        stim = '{8'h00};
        run_job(1'b0, 5, 1'b1, 10, 4'd0, 32'd3, 1'b0);

        // rref_done lands on the watchdog's last cycle: done wins
        stim = '{8'h0F, 8'h01};
        run_job(1'b0, TO, 1'b0, 0, 4'd1, 32'd4, 1'b0);

        // Watchdog: no rref_done; total unchanged, error becomes sticky
        run_job(1'b0, -1, 1'b0, 3, 4'hF, 32'd4, 1'b1);
        stim = '{8'h07};
        run_job(1'b0, 3, 1'b0, 0, 4'd3, 32'd7, 1'b1);

        // Reset during COLLECT clears error and the running total
        stim = '{8'h00, 8'h01};
        issue_job(1'b0);
        rref_phase(2);
        tick();
        tick();
        rst        = 1'b1;
        sol_tvalid = 1'b0;
        sol_tlast  = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_idle_after_reset("rst_collect");
        stim = '{8'h06};
        run_job(1'b0, 3, 1'b0, 0, 4'd2, 32'd2, 1'b0);

        // Reset during REPORT drops the pending result and the total
        stim = '{8'h01};
        issue_job(1'b0);
        rref_phase(3);
        stream_phase(1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_idle_after_reset("rst_report");
        stim = '{8'h03};
        run_job(1'b1, 2, 1'b0, 0, 4'd2, 32'd2, 1'b0);

        repeat (3) @(negedge clk);
        check("pending_results", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "bench did not complete");
    end

endmodule
